fp16_to_fixed: RTL

Streaming converter from IEEE 754-2008 binary16 to signed two's-complement fixed point. It sits at the output end of the fp16 accumulator datapath and turns adder results into the integer/Q-format words consumed by the E203 core and the writeback buffers. It is fully pipelined: two register stages, one conversion per cycle, valid/ready handshakes on both sides, round-to-nearest-even, saturation and exception flags.

---
 rtl/fp16_pkg.sv | 32 +++
 rtl/fp16_unpack.sv | 35 +++
 rtl/fp16_to_fixed.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/fp16_pkg.sv
// Shared binary16 field layout, operand class encoding and field-slice helpers
// used by the fp16 datapath blocks.
package fp16_pkg;

    localparam int EXP_W    = 5;
    localparam int MANT_W   = 10;
    localparam int EXP_BIAS = 15;
    localparam int WORD_W   = 1 + EXP_W + MANT_W;

    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    typedef enum logic [2:0] {
        FP_ZERO = 3'd0,
        FP_SUB  = 3'd1,
        FP_NORM = 3'd2,
        FP_INF  = 3'd3,
        FP_NAN  = 3'd4
    } fp_class_t;

    function automatic logic fp_sign(input logic [WORD_W-1:0] w);
        return w[WORD_W-1];
    endfunction

    function automatic logic [EXP_W-1:0] fp_exp(input logic [WORD_W-1:0] w);
        return w[MANT_W +: EXP_W];
    endfunction

    function automatic logic [MANT_W-1:0] fp_frac(input logic [WORD_W-1:0] w);
        return w[MANT_W-1:0];
    endfunction

endpackage

// File: rtl/fp16_unpack.sv
// Combinational binary16 decoder: sign, operand class, mantissa with the
// hidden bit restored, and effective exponent (subnormals use 1).
module fp16_unpack
    import fp16_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    output logic              sign,
    output logic [2:0]        cls,
    output logic [MANT_W:0]   mant,
    output logic [EXP_W-1:0]  e_eff
);

    logic [EXP_W-1:0]  exp_f;
    logic [MANT_W-1:0] frac_f;

    always_comb begin
        sign   = fp_sign(word);
        exp_f  = fp_exp(word);
        frac_f = fp_frac(word);
        if (exp_f == '0) begin
            mant  = {1'b0, frac_f};
            e_eff = 5'd1;
            cls   = (frac_f == '0) ? FP_ZERO : FP_SUB;
        end else begin
            mant  = {1'b1, frac_f};
            e_eff = exp_f;
            if (exp_f == EXP_MAX) begin
                cls = (frac_f == '0) ? FP_INF : FP_NAN;
            end else begin
                cls = FP_NORM;
            end
        end
    end

endmodule

// File: rtl/fp16_to_fixed.sv
// Two-stage streaming binary16 to signed Q-format converter with
// round-to-nearest-even, saturation and exception flags.
module fp16_to_fixed
    import fp16_pkg::*;
#(
    parameter int OUT_W = 16,
    parameter int FRAC  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_ovf,
    output logic              out_inexact,
    output logic              out_invalid
);

    localparam int SH_W     = 8;
    localparam int RS_MAX   = EXP_BIAS + MANT_W - 1;
    localparam int RS_EXT_W = MANT_W + 1 + RS_MAX;
    // Wide enough for an 11-bit mantissa shifted left by up to 5+31.
    localparam int MAG_W    = 48;

    localparam logic signed [SH_W-1:0] SH_OFS  = 8'(EXP_BIAS + MANT_W - FRAC);
    localparam logic [MAG_W-1:0]       NEG_LIM = 48'd1 << (OUT_W - 1);
    localparam logic [MAG_W-1:0]       POS_LIM = NEG_LIM - 48'd1;

    // Handshake
    logic s1_valid_reg;
    logic out_valid_reg;
    logic s2_adv;
    logic s1_adv;
    logic accept;

    assign s2_adv   = ~out_valid_reg | out_ready;
    assign s1_adv   = s1_valid_reg & s2_adv;
    assign in_ready = ~s1_valid_reg | s1_adv;
    assign accept   = in_valid & in_ready;

    // Stage 1: decode
    logic                   u_sign;
    logic [2:0]             u_cls;
    logic [MANT_W:0]        u_mant;
    logic [EXP_W-1:0]       u_e_eff;
    logic signed [SH_W-1:0] sh_next;

    fp16_unpack u_unpack (
        .word  (in_data),
        .sign  (u_sign),
        .cls   (u_cls),
        .mant  (u_mant),
        .e_eff (u_e_eff)
    );

    assign sh_next = {{(SH_W-EXP_W){1'b0}}, u_e_eff} - SH_OFS;

    logic                   s1_sign_reg;
    fp_class_t              s1_cls_reg;
    logic [MANT_W:0]        s1_mant_reg;
    logic signed [SH_W-1:0] s1_sh_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
        end else if (accept) begin
            s1_valid_reg <= 1'b1;
        end else if (s1_adv) begin
            s1_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_sign_reg <= u_sign;
            s1_cls_reg  <= fp_class_t'(u_cls);
            s1_mant_reg <= u_mant;
            s1_sh_reg   <= sh_next;
        end
    end

    // Stage 2: shift, round, saturate
    logic                 sh_neg;
    logic [4:0]           rs_amt;
    logic [MAG_W-1:0]     mag_shl;
    logic [RS_EXT_W-1:0]  rs_ext;
    logic                 guard;
    logic                 sticky;
    logic                 round_up;
    logic [MANT_W+1:0]    rnd_mag;
    logic [MAG_W-1:0]     mag;
    logic [MAG_W-1:0]     lim;
    logic                 over;
    logic [OUT_W-1:0]     mag_sat;
    logic [OUT_W-1:0]     lim_out;
    logic [OUT_W-1:0]     data_next;
    logic                 ovf_next;
    logic                 inexact_next;
    logic                 invalid_next;

    always_comb begin
        sh_neg   = s1_sh_reg[SH_W-1];
        rs_amt   = 5'(-s1_sh_reg);
        mag_shl  = {{(MAG_W-MANT_W-1){1'b0}}, s1_mant_reg} << s1_sh_reg[SH_W-2:0];
        // Mantissa sits above RS_MAX zero bits so the dropped bits land below it.
        rs_ext   = {s1_mant_reg, {RS_MAX{1'b0}}} >> rs_amt;
        guard    = sh_neg & rs_ext[RS_MAX-1];
        sticky   = sh_neg & (|rs_ext[RS_MAX-2:0]);
        round_up = guard & (sticky | rs_ext[RS_MAX]);
        rnd_mag  = {1'b0, rs_ext[RS_EXT_W-1:RS_MAX]} + {{(MANT_W+1){1'b0}}, round_up};
        mag      = sh_neg ? {{(MAG_W-MANT_W-2){1'b0}}, rnd_mag} : mag_shl;

        lim      = s1_sign_reg ? NEG_LIM : POS_LIM;
        over     = mag > lim;
        mag_sat  = over ? lim[OUT_W-1:0] : mag[OUT_W-1:0];
        lim_out  = s1_sign_reg ? -lim[OUT_W-1:0] : lim[OUT_W-1:0];

        data_next    = s1_sign_reg ? -mag_sat : mag_sat;
        ovf_next     = over;
        inexact_next = over | guard | sticky;
        invalid_next = 1'b0;

        case (s1_cls_reg)
            FP_NAN: begin
                data_next    = '0;
                ovf_next     = 1'b0;
                inexact_next = 1'b0;
                invalid_next = 1'b1;
            end
            FP_INF: begin
                data_next    = lim_out;
                ovf_next     = 1'b1;
                inexact_next = 1'b0;
            end
            default: ;
        endcase
    end

    logic [OUT_W-1:0] data_reg;
    logic             ovf_reg;
    logic             inexact_reg;
    logic             invalid_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            data_reg      <= '0;
            ovf_reg       <= 1'b0;
            inexact_reg   <= 1'b0;
            invalid_reg   <= 1'b0;
        end else if (s2_adv) begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                data_reg    <= data_next;
                ovf_reg     <= ovf_next;
                inexact_reg <= inexact_next;
                invalid_reg <= invalid_next;
            end
        end
    end

    assign out_valid   = out_valid_reg;
    assign out_data    = data_reg;
    assign out_ovf     = ovf_reg;
    assign out_inexact = inexact_reg;
    assign out_invalid = invalid_reg;

endmodule
